// File: rtl/stream_demux.sv
// stream_demux: routes one merged Avalon-ST packet stream to three output
// streams (pkt, meta, usr) using the channel tag carried on the sop beat.
// Packets tagged channel 3 are dropped. Beats that break sop/eop framing
// are counted as protocol errors.
//
// Ports
//   clk, reset_n            single clock, asynchronous active-low reset
//   in_*                    merged input stream; in_channel is sampled on sop
//   in_ready                backpressure toward upstream
//   out_{pkt,meta,usr}_*    per-channel output streams, one register stage each
//   stat_*_cnt              saturating packet, drop and error counters
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | between packets; next accepted beat should be a sop
// FWD   | packet in progress, every beat goes to cur_ch
// DROP  | channel-3 packet in progress, beats are discarded until eop
module stream_demux #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic [511:0]     in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [5:0]       in_empty,
    input  logic [1:0]       in_channel,
    output logic             in_ready,

    output logic [511:0]     out_pkt_data,
    output logic             out_pkt_valid,
    output logic             out_pkt_sop,
    output logic             out_pkt_eop,
    output logic [5:0]       out_pkt_empty,
    input  logic             out_pkt_ready,

    output logic [511:0]     out_meta_data,
    output logic             out_meta_valid,
    output logic             out_meta_sop,
    output logic             out_meta_eop,
    output logic [5:0]       out_meta_empty,
    input  logic             out_meta_ready,

    output logic [511:0]     out_usr_data,
    output logic             out_usr_valid,
    output logic             out_usr_sop,
    output logic             out_usr_eop,
    output logic [5:0]       out_usr_empty,
    input  logic             out_usr_ready,

    output logic [CNT_W-1:0] stat_pkt_cnt,
    output logic [CNT_W-1:0] stat_meta_cnt,
    output logic [CNT_W-1:0] stat_usr_cnt,
    output logic [CNT_W-1:0] stat_drop_cnt,
    output logic [CNT_W-1:0] stat_err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]   state;
    logic [1:0]   cur_ch;
    logic [1:0]   target;
    logic         accept;
    logic         fwd;
    logic         drop_hit;
    logic         err_hit;
    logic [2:0]   load;
    logic [2:0]   out_ready;

    logic [2:0]   stg_valid;
    logic [2:0]   stg_sop;
    logic [2:0]   stg_eop;
    logic [5:0]   stg_empty [3];
    logic [511:0] stg_data  [3];

    assign out_ready = {out_usr_ready, out_meta_ready, out_pkt_ready};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        target = (state == ST_IDLE) ? in_channel : cur_ch;
        // Discarded beats (channel 3 in IDLE, or DROP) never need a free stage.
        if (state == ST_DROP || target == 2'd3)
            in_ready = 1'b1;
        else
            in_ready = !stg_valid[target] || out_ready[target];

        accept   = in_valid && in_ready;
        fwd      = accept && ((state == ST_IDLE && in_sop && in_channel != 2'd3) ||
                              (state == ST_FWD));
        drop_hit = accept && (state == ST_IDLE) && in_sop && (in_channel == 2'd3);
        err_hit  = accept && (((state == ST_IDLE) && !in_sop) ||
                              ((state == ST_FWD) && in_sop));
        for (int i = 0; i < 3; i++)
            load[i] = fwd && (target == 2'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cur_ch <= 2'd0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (in_sop) begin
                        if (in_channel != 2'd3) begin
                            cur_ch <= in_channel;
                            if (!in_eop) state <= ST_FWD;
                        end else if (!in_eop) begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_FWD:  if (in_eop) state <= ST_IDLE;
                ST_DROP: if (in_eop) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output stages: load wins over unload so one beat per cycle is sustained.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= '0;
            stg_sop   <= '0;
            stg_eop   <= '0;
            for (int i = 0; i < 3; i++)
                stg_empty[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load[i]) begin
                    stg_valid[i] <= 1'b1;
                    stg_sop[i]   <= in_sop;
                    stg_eop[i]   <= in_eop;
                    stg_empty[i] <= in_empty;
                end else if (out_ready[i]) begin
                    stg_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload has no reset; it is only observed while valid is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (load[i]) stg_data[i] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_pkt_cnt  <= '0;
            stat_meta_cnt <= '0;
            stat_usr_cnt  <= '0;
            stat_drop_cnt <= '0;
            stat_err_cnt  <= '0;
        end else begin
            if (load[0] && in_eop) stat_pkt_cnt  <= sat_inc(stat_pkt_cnt);
            if (load[1] && in_eop) stat_meta_cnt <= sat_inc(stat_meta_cnt);
            if (load[2] && in_eop) stat_usr_cnt  <= sat_inc(stat_usr_cnt);
            if (drop_hit)          stat_drop_cnt <= sat_inc(stat_drop_cnt);
            if (err_hit)           stat_err_cnt  <= sat_inc(stat_err_cnt);
        end
    end

    assign out_pkt_data   = stg_data[0];
    assign out_pkt_valid  = stg_valid[0];
    assign out_pkt_sop    = stg_sop[0];
    assign out_pkt_eop    = stg_eop[0];
    assign out_pkt_empty  = stg_empty[0];

    assign out_meta_data  = stg_data[1];
    assign out_meta_valid = stg_valid[1];
    assign out_meta_sop   = stg_sop[1];
    assign out_meta_eop   = stg_eop[1];
    assign out_meta_empty = stg_empty[1];

    assign out_usr_data   = stg_data[2];
    assign out_usr_valid  = stg_valid[2];
    assign out_usr_sop    = stg_sop[2];
    assign out_usr_eop    = stg_eop[2];
    assign out_usr_empty  = stg_empty[2];

endmodule
